// File: rtl/config_pkg.sv
// Core-wide configuration constants shared by the execute-stage units.
//   DURLEN : width of the divide/sqrt iteration count.
package config_pkg;
  localparam int DURLEN = 6;
endpackage : config_pkg

// File: rtl/fdivsqrt_pkg.sv
// Types shared by the divide/sqrt sequencer and its step counter.
package fdivsqrt_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fdivsqrt_state_t;
endpackage : fdivsqrt_pkg

// File: rtl/fdivsqrt_stepcnt.sv
// Loadable down counter tracking the remaining divide/sqrt iteration steps.
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   clr_i        : force the count to zero (highest priority)
//   load_i       : load load_val_i
//   load_val_i   : new iteration count
//   dec_i        : decrement by one; saturates at zero, never wraps
//   is_one_o     : count equals one (the current step is the final one)
module fdivsqrt_stepcnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         is_one_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign is_one_o = (cnt_q == W'(1));

endmodule : fdivsqrt_stepcnt

// File: rtl/fdivsqrt_seq.sv
// Sequencer for the shared radix-2^r divide/sqrt iteration datapath.
// Accepts one op while idle, steps the datapath for the requested number of
// iterations, then holds the result valid until Memory consumes it.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   StartE        : request valid in Execute
//   SpecialCaseE  : operands need no iteration; result ready next cycle
//   CyclesE       : iterations required (0 is treated as 1), sampled on accept
//   FlushE        : squash the in-flight op
//   StallM        : Memory cannot consume the result this cycle
//   ReadyE        : idle; a request is accepted this cycle if StartE
//   BusyE         : stall Execute (iterating, or result held under StallM)
//   InitE         : load datapath initial state (accept cycle, combinational)
//   IterEnE       : datapath performs one step this cycle
//   LastIterE     : this step is the final one
//   DoneM         : result valid for Memory
module fdivsqrt_seq
  import fdivsqrt_pkg::*;
#(
  parameter int DURLEN = config_pkg::DURLEN
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              StartE,
  input  logic              SpecialCaseE,
  input  logic [DURLEN-1:0] CyclesE,
  input  logic              FlushE,
  input  logic              StallM,
  output logic              ReadyE,
  output logic              BusyE,
  output logic              InitE,
  output logic              IterEnE,
  output logic              LastIterE,
  output logic              DoneM
);

  fdivsqrt_state_t state_q, state_d;

  logic              accept;
  logic              cnt_load, cnt_clr, cnt_is_one;
  logic [DURLEN-1:0] cnt_load_val;

  assign accept = (state_q == IDLE) & StartE & ~FlushE;

  // A zero iteration count still needs one step to produce a result.
  assign cnt_load_val = (CyclesE == '0) ? DURLEN'(1) : CyclesE;

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // SpecialCaseE/CyclesE are only looked at on accept, so X there is harmless.
        if (accept) begin
          if (SpecialCaseE) begin
            state_d = DONE;
          end else begin
            state_d  = BUSY;
            cnt_load = 1'b1;
          end
        end
      end
      BUSY: begin
        // Flush wins over completion on the final step.
        if (FlushE) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_is_one) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (FlushE) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (!StallM) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  fdivsqrt_stepcnt #(
    .W (DURLEN)
  ) u_stepcnt (
    .clk        (clk),
    .resetn     (resetn),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (state_q == BUSY),
    .is_one_o   (cnt_is_one)
  );

  assign ReadyE    = (state_q == IDLE);
  assign InitE     = accept;
  assign IterEnE   = (state_q == BUSY);
  assign LastIterE = (state_q == BUSY) & cnt_is_one;
  assign DoneM     = (state_q == DONE);
  assign BusyE     = (state_q == BUSY) | ((state_q == DONE) & StallM);

endmodule : fdivsqrt_seq
